input_fifo_buffer: RTL and testbench

INPUT_FIFO_BUFFER -- requirements
Module: input_fifo_buffer

---
 rtl/input_fifo_buffer_pkg.sv | 30 +++
 rtl/input_fifo_buffer_ram.sv | 43 ++++
 rtl/input_fifo_buffer.sv | 137 +++++++++++++
 tb/tb_input_fifo_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/input_fifo_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : input_fifo_buffer_pkg
//  Purpose  : Shared defaults and helpers for the input FIFO buffer.
//             Holds the default vector geometry (lanes and lane width), the
//             occupancy-width helper, and the operation encoding used to
//             update the occupancy counter.
//  Revision : 1.0  initial release
// ============================================================================
package input_fifo_buffer_pkg;

    localparam int C_DEFAULT_N          = 8;
    localparam int C_DEFAULT_DATA_WIDTH = 32;

    // Per-cycle queue operation, formed as {write_accepted, read_accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // Occupancy must represent 0..depth inclusive, hence one bit more than
    // the pointer width.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_fifo_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module   : ram_dual_port
//  Purpose  : Simple dual-port RAM, port A write-only, port B read-only,
//             read latency of one clock. Contents are not reset.
//  Ports    : clk                         - clock, rising edge
//             a_we / a_addr / a_wdata     - write port
//             b_re / b_addr               - read request / address
//             b_rdata                     - registered read data
//  Revision : 1.0  initial release
// ============================================================================
module ram_dual_port #(
    parameter int WIDTH  = 33,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_wdata,
    input  logic              b_re,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [WIDTH-1:0]  b_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] b_rdata_q;

    // Read returns the pre-write contents on an address collision; the FIFO
    // never reads the slot it is writing, so this ordering is never observed.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem_q[a_addr] <= a_wdata;
        end
        if (b_re) begin
            b_rdata_q <= mem_q[b_addr];
        end
    end

    assign b_rdata = b_rdata_q;

endmodule
`default_nettype wire

// File: rtl/input_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : input_fifo_buffer
//  Purpose  : Synchronous FIFO of N-lane vectors plus an end-of-frame flag.
//             Registered read (valid_out one cycle after an accepted
//             dequeue), no write-to-read bypass, sticky overflow flag.
//  Ports    : clk, rst                    - clock / sync active-high reset
//             enqueue, eof_in, vector_in  - write side
//             dequeue                     - read request
//             valid_out, eof_out,
//             vector_out                  - read data, valid one cycle later
//             full, empty, almost_full,
//             occupancy                   - occupancy status
//             overflow                    - sticky: write attempted while full
//  Revision : 1.0  initial release
// ============================================================================
module input_fifo_buffer
    import input_fifo_buffer_pkg::*;
#(
    parameter int N          = C_DEFAULT_N,
    parameter int DATA_WIDTH = C_DEFAULT_DATA_WIDTH,
    parameter int IB_DEPTH   = 4,
    parameter int AF_THRESH  = IB_DEPTH - 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enqueue,
    input  logic                              eof_in,
    input  logic [N*DATA_WIDTH-1:0]           vector_in,
    input  logic                              dequeue,
    output logic                              valid_out,
    output logic                              eof_out,
    output logic [N*DATA_WIDTH-1:0]           vector_out,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic [occ_width(IB_DEPTH)-1:0]    occupancy,
    output logic                              overflow
);

    localparam int C_PTR_W   = $clog2(IB_DEPTH);
    localparam int C_OCC_W   = occ_width(IB_DEPTH);
    localparam int C_ENTRY_W = N * DATA_WIDTH + 1;

    localparam logic [C_OCC_W-1:0] C_DEPTH_OCC = C_OCC_W'(IB_DEPTH);
    localparam logic [C_OCC_W-1:0] C_AF_OCC    = C_OCC_W'(AF_THRESH);

    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_OCC_W-1:0] occupancy_q, occupancy_d;
    logic               valid_out_q, valid_out_d;
    logic               overflow_q, overflow_d;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_en;
    logic               w_rd_en;
    fifo_op_e           w_op;
    logic [C_ENTRY_W-1:0] w_wr_entry;
    logic [C_ENTRY_W-1:0] w_rd_entry;

    // Status flags derive from the occupancy register, so they always agree
    // with the occupancy value presented in the same cycle.
    assign w_full  = (occupancy_q == C_DEPTH_OCC);
    assign w_empty = (occupancy_q == '0);

    // A full queue blocks writes even when a read frees a slot this cycle.
    assign w_wr_en = enqueue && !w_full  && !rst;
    assign w_rd_en = dequeue && !w_empty && !rst;
    assign w_op    = fifo_op_e'({w_wr_en, w_rd_en});

    // EOF occupies the LSB of each stored entry.
    assign w_wr_entry = {vector_in, eof_in};

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occupancy_d = occupancy_q;
        valid_out_d = w_rd_en;
        overflow_d  = overflow_q || (enqueue && w_full);

        // Power-of-two depth lets the pointers wrap by natural overflow.
        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
        end
        if (w_rd_en) begin
            rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
        end

        case (w_op)
            OP_WRITE: occupancy_d = occupancy_q + C_OCC_W'(1);
            OP_READ:  occupancy_d = occupancy_q - C_OCC_W'(1);
            default:  occupancy_d = occupancy_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occupancy_q <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occupancy_q <= occupancy_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
        end
    end

    ram_dual_port #(
        .WIDTH  (C_ENTRY_W),
        .DEPTH  (IB_DEPTH),
        .ADDR_W (C_PTR_W)
    ) u_ram (
        .clk     (clk),
        .a_we    (w_wr_en),
        .a_addr  (wr_ptr_q),
        .a_wdata (w_wr_entry),
        .b_re    (w_rd_en),
        .b_addr  (rd_ptr_q),
        .b_rdata (w_rd_entry)
    );

    assign valid_out   = valid_out_q;
    assign vector_out  = w_rd_entry[C_ENTRY_W-1:1];
    assign eof_out     = w_rd_entry[0];
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (occupancy_q >= C_AF_OCC);
    assign occupancy   = occupancy_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_input_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_fifo_buffer
//  Purpose  : Self-checking bench for input_fifo_buffer (N=4, DATA_WIDTH=8,
//             IB_DEPTH=4, AF_THRESH=3). Directed table, hand sequences and
//             random traffic checked against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_input_fifo_buffer;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int OW = 3;

    logic            clk = 1'b0;
    logic            rst, enqueue, eof_in, dequeue;
    logic [N*DW-1:0] vector_in;
    logic            valid_out, eof_out, full, empty, almost_full, overflow;
    logic [N*DW-1:0] vector_out;
    logic [OW-1:0]   occupancy;

    always #5 clk = ~clk;

    input_fifo_buffer #(
        .N          (N),
        .DATA_WIDTH (DW),
        .IB_DEPTH   (D),
        .AF_THRESH  (AF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enqueue     (enqueue),
        .eof_in      (eof_in),
        .vector_in   (vector_in),
        .dequeue     (dequeue),
        .valid_out   (valid_out),
        .eof_out     (eof_out),
        .vector_out  (vector_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .occupancy   (occupancy),
        .overflow    (overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of {vector, eof} entries.
    logic [N*DW:0]   mq[$];
    logic            m_ovf   = 1'b0;
    logic            m_valid = 1'b0;
    logic [N*DW-1:0] m_vec   = '0;
    logic            m_eof   = 1'b0;

    typedef struct {
        logic            rst;
        logic            enq;
        logic            eof;
        logic [N*DW-1:0] vec;
        logic            deq;
        int              occ;
        logic            valid;
        logic [N*DW-1:0] exp_vec;
        logic            exp_eof;
        logic            ovf;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic r, logic e, logic f, logic [N*DW-1:0] v, logic d,
                                int o, logic vl, logic [N*DW-1:0] ev, logic ef, logic ov);
        vec_t t;
        t.rst = r; t.enq = e; t.eof = f; t.vec = v; t.deq = d;
        t.occ = o; t.valid = vl; t.exp_vec = ev; t.exp_eof = ef; t.ovf = ov;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic f,
                              input logic [N*DW-1:0] v, input logic d);
        logic [N*DW:0] ent;
        bit was_full;
        if (r) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            was_full = (mq.size() == D);
            m_valid  = 1'b0;
            if (d && mq.size() > 0) begin
                ent     = mq.pop_front();
                m_valid = 1'b1;
                m_vec   = ent[N*DW:1];
                m_eof   = ent[0];
            end
            if (e && was_full) m_ovf = 1'b1;
            else if (e)        mq.push_back({v, f});
        end
    endtask

    task automatic model_check();
        chk("occupancy",   64'(occupancy),   64'(mq.size()));
        chk("full",        64'(full),        64'(mq.size() == D));
        chk("empty",       64'(empty),       64'(mq.size() == 0));
        chk("almost_full", 64'(almost_full), 64'(mq.size() >= AF));
        chk("overflow",    64'(overflow),    64'(m_ovf));
        chk("valid_out",   64'(valid_out),   64'(m_valid));
        if (m_valid) begin
            chk("vector_out", 64'(vector_out), 64'(m_vec));
            chk("eof_out",    64'(eof_out),    64'(m_eof));
        end
    endtask

    // Drive one cycle of inputs, clock it, then check outputs 1 time unit later.
    task automatic cycle(input logic r, input logic e, input logic f,
                         input logic [N*DW-1:0] v, input logic d);
        rst = r; enqueue = e; eof_in = f; vector_in = v; dequeue = d;
        @(posedge clk);
        model_step(r, e, f, v, d);
        #1;
        model_check();
    endtask

    initial begin
        rst = 1'b1; enqueue = 1'b0; eof_in = 1'b0; dequeue = 1'b0; vector_in = '0;

        //                rst enq eof vec            deq  occ val exp_vec        eof ovf
        tbl[0]  = mk(1, 0, 0, 32'h0,         0,   0, 0, 32'h0,         0, 0);
        tbl[1]  = mk(0, 1, 0, 32'h04030201,  0,   1, 0, 32'h0,         0, 0);
        tbl[2]  = mk(0, 1, 0, 32'h08070605,  0,   2, 0, 32'h0,         0, 0);
        tbl[3]  = mk(0, 0, 0, 32'h0,         1,   1, 1, 32'h04030201,  0, 0);
        tbl[4]  = mk(0, 0, 0, 32'h0,         1,   0, 1, 32'h08070605,  0, 0);
        tbl[5]  = mk(0, 0, 0, 32'h0,         0,   0, 0, 32'h0,         0, 0);
        tbl[6]  = mk(0, 1, 0, 32'hA1A1A1A1,  0,   1, 0, 32'h0,         0, 0);
        tbl[7]  = mk(0, 1, 0, 32'hA2A2A2A2,  0,   2, 0, 32'h0,         0, 0);
        tbl[8]  = mk(0, 1, 0, 32'hA3A3A3A3,  0,   3, 0, 32'h0,         0, 0);
        tbl[9]  = mk(0, 1, 0, 32'hA4A4A4A4,  0,   4, 0, 32'h0,         0, 0);
        tbl[10] = mk(0, 1, 0, 32'hA5A5A5A5,  0,   4, 0, 32'h0,         0, 1);
        tbl[11] = mk(0, 0, 0, 32'h0,         0,   4, 0, 32'h0,         0, 1);
        tbl[12] = mk(0, 1, 0, 32'hC0C0C0C0,  1,   3, 1, 32'hA1A1A1A1,  0, 1);
        tbl[13] = mk(1, 0, 0, 32'h0,         1,   0, 0, 32'h0,         0, 0);
        tbl[14] = mk(0, 0, 0, 32'h0,         0,   0, 0, 32'h0,         0, 0);
        tbl[15] = mk(0, 1, 1, 32'hB0B1B2B3,  1,   1, 0, 32'h0,         0, 0);
        tbl[16] = mk(0, 0, 0, 32'h0,         1,   0, 1, 32'hB0B1B2B3,  1, 0);
        tbl[17] = mk(0, 0, 0, 32'h0,         1,   0, 0, 32'h0,         0, 0);

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].rst, tbl[i].enq, tbl[i].eof, tbl[i].vec, tbl[i].deq);
            chk($sformatf("tbl%0d_occ", i),   64'(occupancy),   64'(tbl[i].occ));
            chk($sformatf("tbl%0d_full", i),  64'(full),        64'(tbl[i].occ == D));
            chk($sformatf("tbl%0d_empty", i), 64'(empty),       64'(tbl[i].occ == 0));
            chk($sformatf("tbl%0d_af", i),    64'(almost_full), 64'(tbl[i].occ >= AF));
            chk($sformatf("tbl%0d_ovf", i),   64'(overflow),    64'(tbl[i].ovf));
            chk($sformatf("tbl%0d_valid", i), 64'(valid_out),   64'(tbl[i].valid));
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d_vec", i), 64'(vector_out), 64'(tbl[i].exp_vec));
                chk($sformatf("tbl%0d_eof", i), 64'(eof_out),    64'(tbl[i].exp_eof));
            end
        end

        // EOF tagged on the third of three writes only.
        cycle(0, 1, 0, 32'h11111111, 0);
        cycle(0, 1, 0, 32'h22222222, 0);
        cycle(0, 1, 1, 32'h33333333, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, '0, 1);
            chk($sformatf("eof_seq%0d", k), 64'(eof_out), 64'(k == 2));
        end

        // Steady state at occupancy 2 with simultaneous read and write; the
        // pointers wrap several times.
        cycle(0, 1, 0, 32'h50505050, 0);
        cycle(0, 1, 0, 32'h51515151, 0);
        for (int k = 0; k < 10; k++) begin
            cycle(0, 1, 0, 32'h60606060 + 32'(k), 1);
            chk($sformatf("steady_occ%0d", k), 64'(occupancy), 64'd2);
        end
        cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 0, '0, 0);

        // Random traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 99) < 60),
                  1'($urandom),
                  32'($urandom),
                  ($urandom_range(0, 99) < 50));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
